// File: rtl/if_prefetch_stage_if.sv
// rtl/if_prefetch_stage_if.sv - instruction memory and decode handshake bundle for the prefetch stage
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_rdata, out_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - prefetching fetch stage with DEPTH-entry queue; IF_PREFETCH_BYPASS_EN adds empty-queue response bypass
module if_prefetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  if_prefetch_stage_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [PTR_W+1:0]  CREDIT_MAX = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W+1)'(1);

  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] inflightAddr;
  logic              inflight;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] qAddr [DEPTH];
  logic [INST_W-1:0] qInst [DEPTH];

  logic              headValid;
  logic              issue;
  logic              push;
  logic              pop;
  logic [PTR_W+1:0]  credit;
  logic [ADDR_W-1:0] outAddr;
  logic [INST_W-1:0] outInst;

  // Credit ignores a same-cycle pop, so a full queue always waits one cycle before refilling.
  assign credit    = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
  assign headValid = (count != '0);
  assign issue     = rst && !branch_taken && (credit < CREDIT_MAX);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetchPc;

`ifdef IF_PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass = !headValid && inflight && !branch_taken;
`endif

  always_comb begin
    outAddr       = qAddr[rdPtr];
    outInst       = qInst[rdPtr];
    bus.out_valid = headValid;
    pop           = headValid && bus.out_ready && !branch_taken;
    push          = inflight && !branch_taken;
`ifdef IF_PREFETCH_BYPASS_EN
    if (!headValid) begin
      outAddr = inflightAddr;
      outInst = bus.imem_rdata;
    end
    bus.out_valid = headValid || bypass;
    push          = inflight && !branch_taken && !(bypass && bus.out_ready);
`endif
    bus.out_pc   = bus.out_valid ? outAddr + STEP : '0;
    bus.out_inst = bus.out_valid ? outInst : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc      <= RESET_PC;
      inflight     <= 1'b0;
      inflightAddr <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      count        <= '0;
    end else if (branch_taken) begin
      fetchPc  <= branch_addr;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflightAddr <= fetchPc;
        fetchPc      <= fetchPc + STEP;
      end
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue payload needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      qAddr[wrPtr] <= inflightAddr;
      qInst[wrPtr] <= bus.imem_rdata;
    end
  end
endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between a 1-cycle-latency synchronous instruction memory and decode. Keeps fetching ahead while decode is frozen, flushes queue and in-flight request on a taken branch, and hands decode one (pc + PC_STEP, instruction) pair per cycle under a valid/ready handshake. Sits at the front of the pipeline, replacing the single-register fetch stage.

## Interface
- ADDR_W, 32, PC / address width
- INST_W, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch address after reset
- PC_STEP, 4, increment between sequential fetches
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- branch_taken  in  1  redirect request, highest priority
- branch_addr  in  ADDR_W  redirect target
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address, valid with imem_req
- imem_rdata  in  INST_W  read data, valid the cycle after imem_req
- out_valid  out  1  queue head presented to decode
- out_ready  in  1  decode accepts (driven as ~freeze upstream)
- out_pc  out  ADDR_W  head fetch address + PC_STEP
- out_inst  out  INST_W  head instruction

## Operation
- State: fetch_pc, queue (DEPTH × {addr, inst}), rd/wr pointers, count (0..DEPTH), inflight flag + inflight addr.
- Issue: imem_req = !branch_taken && (count + inflight) < DEPTH; imem_addr = fetch_pc; on issue fetch_pc += PC_STEP (modulo 2^ADDR_W), inflight ← 1 with addr latched; else inflight ← 0.
- Response: cycle after issue, {inflight addr, imem_rdata} written at wr pointer, count +1.
- Pop: out_valid && out_ready → rd pointer advances, count −1. Push and pop in same cycle → count unchanged.
- Credit check does not count a same-cycle pop (conservative; never overflows).
- out_pc = head addr + PC_STEP; out_pc and out_inst forced to 0 when out_valid = 0.
- Branch (branch_taken = 1): queue emptied (pointers, count → 0), response arriving this cycle discarded, pop this cycle ignored, no request issued, fetch_pc ← branch_addr, inflight ← 0.
- Pointers wrap modulo DEPTH; count = DEPTH is full, 0 is empty.

## Timing
- Reset (async, rst = 0): fetch_pc = RESET_PC, count = 0, inflight = 0, imem_req = 0, imem_addr = RESET_PC, out_valid = 0, out_pc = 0, out_inst = 0.
- First request in first cycle after rst deasserts.
- Request in cycle c → entry visible (out_valid) in cycle c+2; branch in cycle t → request at branch_addr in t+1, out_valid in t+3.
- Steady state with out_ready = 1: one instruction per cycle, gap-free.
- out_ready = 0: queue fills; imem_req drops once count + inflight = DEPTH; resumes the cycle after a pop frees credit.
- Reset mid-operation: all state cleared immediately, in-flight response ignored.

## Configuration
- IF_PREFETCH_BYPASS_EN defined: when queue is empty and a response arrives, it is presented combinationally on out_valid/out_pc/out_inst in the response cycle; if accepted it is not written, else written normally. Request in c → out_valid in c+1; branch in t → out_valid in t+2. Branch in the response cycle still discards it.
- Undefined: no bypass; latencies as in Timing.

## Test plan
- Reset release, out_ready = 1, imem_rdata = addr-derived: imem_addr 0,4,8,… from cycle 1; out_valid from cycle 3; out_pc 4,8,12,… every cycle, no bubbles.
- out_ready = 0 for 10 cycles from steady state: exactly DEPTH = 4 entries held, imem_req low after fill; release → out_pc continues in order, no loss or duplicate.
- branch_taken with branch_addr = 0x100 while queue holds 3 entries and a request in flight: out_valid low next two cycles, imem_addr = 0x100 next cycle, first out_pc = 0x104 at t+3 (t+2 with IF_PREFETCH_BYPASS_EN).
- Branch coincident with a pop and a response: neither popped entry nor response reaches decode twice or at all after the branch; count = 0.
- rst asserted mid-stream with queue full: all outputs at reset values same cycle; refetch restarts at RESET_PC.
- fetch_pc at 2^ADDR_W − 4: next imem_addr wraps to 0.
